// File: rtl/mem_stage_port_if.sv
// Pipeline-side request/response bundle for mem_stage_port.
// The EX/MEM stage uses the master view; the memory stage uses the slave view.
interface mem_stage_port_if #(
  parameter int ADDR_W = 18
);
  logic              ex_mem_req;
  logic              ex_mem_we;
  logic [1:0]        ex_mem_size;
  logic              ex_mem_unsigned;
  logic [ADDR_W+1:0] ex_mem_addr;
  logic [31:0]       ex_mem_wdata;
  logic              mem_stall;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wdone;
  logic              mem_fault;

  modport master (
    output ex_mem_req, ex_mem_we, ex_mem_size, ex_mem_unsigned, ex_mem_addr, ex_mem_wdata,
    input  mem_stall, mem_rdata, mem_rvalid, mem_wdone, mem_fault
  );

  modport slave (
    input  ex_mem_req, ex_mem_we, ex_mem_size, ex_mem_unsigned, ex_mem_addr, ex_mem_wdata,
    output mem_stall, mem_rdata, mem_rvalid, mem_wdone, mem_fault
  );
endinterface

// File: rtl/mem_stage_port.sv
// Memory-stage initiator: turns EX/MEM load/store requests into timed memory-controller accesses.
// Define MEMSTAGE_RMW_EN to build read-modify-write support for byte/half stores.
module mem_stage_port #(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  mem_stage_port_if.slave   pipe,
  output logic              mem_mc_en,
  output logic              mem_mc_rw,
  output logic [ADDR_W-1:0] mem_mc_addr,
  inout  wire  [31:0]       mem_mc_data
);

  localparam logic [2:0] LAST = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
`ifdef MEMSTAGE_RMW_EN
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              last;
  logic              bad_req;

  // Select the addressed lane and extend it to a full word.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{b[7] & ~uns}}, b};
      2'b01:   return {{16{h[15] & ~uns}}, h};
      default: return w;
    endcase
  endfunction

`ifdef MEMSTAGE_RMW_EN
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00)  r[{a, 3'b000} +: 8] = d[7:0];
    else if (a[1])    r[31:16] = d[15:0];
    else              r[15:0]  = d[15:0];
    return r;
  endfunction
`endif

  always_comb begin
    bad_req = (pipe.ex_mem_size == 2'b11) ||
              (pipe.ex_mem_size == 2'b01 && pipe.ex_mem_addr[0]) ||
              (pipe.ex_mem_size == 2'b10 && pipe.ex_mem_addr[1:0] != 2'b00);
`ifndef MEMSTAGE_RMW_EN
    // Without RMW there is no way to write a partial word.
    bad_req = bad_req || (pipe.ex_mem_we && pipe.ex_mem_size != 2'b10);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last    = (cnt_q == LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        if (pipe.ex_mem_req) begin
          addr_d  = pipe.ex_mem_addr;
          size_d  = pipe.ex_mem_size;
          we_d    = pipe.ex_mem_we;
          uns_d   = pipe.ex_mem_unsigned;
          wdata_d = pipe.ex_mem_wdata;
          if (bad_req)                     state_d = S_FAULT;
          else if (!pipe.ex_mem_we)        state_d = S_RD;
          else if (pipe.ex_mem_size == 2'b10) state_d = S_WR;
`ifdef MEMSTAGE_RMW_EN
          else                             state_d = S_RMW_RD;
`else
          else                             state_d = S_FAULT;
`endif
        end
      end
      S_RD: begin
        if (last) begin
          cnt_d   = 3'd0;
          rdata_d = load_extend(mem_mc_data, addr_q[1:0], size_q, uns_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR: begin
        if (last) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef MEMSTAGE_RMW_EN
      S_RMW_RD: begin
        if (last) begin
          cnt_d   = 3'd0;
          wdata_d = store_merge(mem_mc_data, wdata_q, addr_q[1:0], size_q);
          state_d = S_RMW_WR;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RMW_WR: begin
        if (last) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Enable stays high across RMW_RD -> RMW_WR; only the direction flips.
  always_comb begin
    mem_mc_en = 1'b0;
    mem_mc_rw = 1'b0;
    case (state_q)
      S_RD:     mem_mc_en = 1'b1;
      S_WR:     begin mem_mc_en = 1'b1; mem_mc_rw = 1'b1; end
`ifdef MEMSTAGE_RMW_EN
      S_RMW_RD: mem_mc_en = 1'b1;
      S_RMW_WR: begin mem_mc_en = 1'b1; mem_mc_rw = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign mem_mc_addr = addr_q[ADDR_W+1:2];
  assign mem_mc_data = mem_mc_rw ? wdata_q : 32'bz;

  assign pipe.mem_stall  = (state_q != S_IDLE && state_q != S_DONE && state_q != S_FAULT) ||
                           (state_q == S_IDLE && pipe.ex_mem_req);
  assign pipe.mem_rdata  = rdata_q;
  assign pipe.mem_rvalid = (state_q == S_DONE) && !we_q;
  assign pipe.mem_wdone  = (state_q == S_DONE) && we_q;
  assign pipe.mem_fault  = (state_q == S_FAULT);

endmodule

// File: doc/mem_stage_port.md
Name: mem_stage_port

Overview:
- Memory-stage initiator for the memory controller's memory-side port.
- Takes load/store requests from the EX/MEM pipeline register and drives mem_mc_en/mem_mc_rw/mem_mc_addr and the bidirectional mem_mc_data.
- Holds each access for the controller's two-half-word sequence, then returns aligned, extended load data to the pipeline.
- Stalls the pipeline for the whole transaction.

Parameters:
- ADDR_W, 18: word-address width on the controller port.
- ACCESS_CYCLES, 2: cycles mem_mc_en is held per 32-bit access (one per 16-bit RAM half); legal range 1..7.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_mem_req  in  1  memory request valid
- ex_mem_we  in  1  1 = store, 0 = load
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ex_mem_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- ex_mem_addr  in  ADDR_W+2  byte address
- ex_mem_wdata  in  32  store data, right-justified
- mem_stall  out  1  pipeline hold
- mem_rdata  out  32  load result
- mem_rvalid  out  1  one-cycle pulse, load complete
- mem_wdone  out  1  one-cycle pulse, store complete
- mem_fault  out  1  one-cycle pulse, misaligned/illegal/unsupported request
- mem_mc_en  out  1  controller access enable
- mem_mc_rw  out  1  1 = write, 0 = read
- mem_mc_addr  out  ADDR_W  word address = ex_mem_addr[ADDR_W+1:2]
- mem_mc_data  inout  32  driven only while writing, else high-Z

Behaviour:
- Reset (async, low): state IDLE. mem_mc_en, mem_mc_rw, mem_rvalid, mem_wdone and mem_fault are 0. mem_rdata = 0, mem_mc_addr = 0, mem_mc_data = Z. The internal counter and latches are cleared. Reset mid-transaction aborts it immediately with no completion pulse.
- Byte order is little-endian: byte lane k = bits 8k+7:8k, where k = addr[1:0]. The half lane is selected by addr[1].
- Alignment:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size 11 is illegal.
  - On violation: IDLE -> FAULT (1 cycle, mem_fault=1, no mc access) -> IDLE.
- mem_stall = (state != IDLE && state != DONE && state != FAULT) || (state == IDLE && ex_mem_req). It is combinational, so the pipeline holds from the request cycle onward.
- Requests are latched (addr, size, we, unsigned, wdata) on the IDLE edge where ex_mem_req=1. Inputs are ignored until return to IDLE.
- States:
  - IDLE
  - RD: mem_mc_en=1, rw=0, ACCESS_CYCLES cycles. Data is captured from mem_mc_data on the edge ending the last cycle.
  - WR: mem_mc_en=1, rw=1, mem_mc_data driven, ACCESS_CYCLES cycles.
  - RMW_RD and RMW_WR: same as RD and WR.
  - DONE: 1 cycle.
  - FAULT: 1 cycle.
- Transitions:
  - load: IDLE -> RD -> DONE
  - word store: IDLE -> WR -> DONE
  - sub-word store: IDLE -> RMW_RD -> RMW_WR -> DONE
  - DONE -> IDLE always.
- Counter:
  - 3 bits, cleared on entry to each access state.
  - Leaves the state when count = ACCESS_CYCLES-1.
  - mem_mc_en stays high continuously across RMW_RD -> RMW_WR; only rw toggles.
- Load result:
  - The selected lane is sign- or zero-extended to 32 bits.
  - It is registered into mem_rdata at entry to DONE; mem_rvalid=1 in DONE.
  - mem_rdata holds its value until the next load completes.
- Store merge: the captured word has the target byte/half lane replaced by the low 8/16 bits of wdata. Other lanes are unchanged.
- mem_wdone=1 in DONE for stores.
- Latency, request edge = cycle 0 (ACCESS_CYCLES=2):
  - load: rvalid in cycle 3
  - word store: wdone in cycle 3
  - RMW store: wdone in cycle 5
  - fault: pulse in cycle 1
- Back-to-back: a request asserted during DONE is not accepted. It is accepted on the following IDLE cycle.

Optional Feature:
- MEMSTAGE_RMW_EN defined: sub-word stores use read-modify-write as above.
- Undefined:
  - RMW_RD/RMW_WR are not built.
  - Any byte/half store goes IDLE -> FAULT with no mc access.
  - Sub-word loads remain supported.

Test Plan:
- Load word, mem_mc_data returns 0xDEADBEEF, addr 0x00010 -> mem_mc_addr 0x00004, en=1 rw=0 for 2 cycles, rvalid in cycle 3, rdata=0xDEADBEEF.
- Load byte signed at addr 0x00013, memory 0x80FF1234 -> rdata=0xFFFFFF80; same addr unsigned -> 0x00000080.
- Store word 0xCAFEF00D at addr 0x00020 -> en=1 rw=1 for 2 cycles, mem_mc_data=0xCAFEF00D, then Z, wdone in cycle 3.
- With MEMSTAGE_RMW_EN: store half 0xBEEF at addr 0x00006, memory 0x11223344 -> read 2 cycles, write 0xBEEF3344, wdone in cycle 5. Without the macro: mem_fault in cycle 1, mem_mc_en never asserted.
- Misaligned word at addr 0x00002 or size 11 -> mem_fault pulse in cycle 1, no mc access, mem_stall high only in cycle 0.
- Reset asserted in cycle 2 of an RMW store -> all outputs 0, mem_mc_data Z immediately, no wdone. The next request after reset release completes normally.
